// File: rtl/bus_arbiter.sv
// Two-port memory bus arbiter: data port (D) has priority over fetch (F), with a
// bounded D streak so fetch cannot starve, and a per-transaction timeout.
module bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [ADDR_W-1:0]     f_addr,
  output logic                  f_ack,
  output logic                  f_err,
  input  logic                  d_req,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic                  d_write,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic                  d_ack,
  output logic                  d_err,
  output logic [DATA_W-1:0]     rdata,
  output logic                  bus_valid,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic                  bus_write,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W/8-1:0]   bus_wstrb,
  input  logic                  bus_ready,
  input  logic [DATA_W-1:0]     bus_rdata
);

  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);
  localparam logic [3:0]  STREAK_MAX = 4'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, GRANT_F, GRANT_D} state_t;

  state_t      state_q;
  logic [3:0]  streak_q;
  logic [15:0] timer_q;

  logic sel_f, sel_d, expire, done, pick_d;

  assign sel_f  = (state_q == GRANT_F);
  assign sel_d  = (state_q == GRANT_D);
  assign expire = (timer_q == TO_LAST);
  // bus_ready on the expiry cycle still counts as a normal completion
  assign done   = (sel_f || sel_d) && (bus_ready || expire);
  assign pick_d = d_req && (!f_req || (streak_q < STREAK_MAX));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
      timer_q  <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_d) begin
            state_q  <= GRANT_D;
            timer_q  <= 16'd0;
            streak_q <= !f_req ? 4'd0 : (streak_q == 4'hF) ? 4'hF : streak_q + 4'd1;
          end else if (f_req) begin
            state_q  <= GRANT_F;
            timer_q  <= 16'd0;
            streak_q <= 4'd0;
          end
        end
        default: begin
          if (done) state_q <= IDLE;
          else      timer_q <= timer_q + 16'd1;
        end
      endcase
    end
  end

  // Bus side follows the state register directly so reset drops bus_valid at once
  assign bus_valid = sel_f || sel_d;
  assign bus_addr  = sel_d ? d_addr : sel_f ? f_addr : '0;
  assign bus_write = sel_d && d_write;
  assign bus_wdata = sel_d ? d_wdata : '0;
  assign bus_wstrb = sel_d ? d_wstrb : '0;

  assign f_ack = sel_f && done;
  assign d_ack = sel_d && done;
  assign f_err = f_ack && !bus_ready;
  assign d_err = d_ack && !bus_ready;
  assign rdata = (done && bus_ready) ? bus_rdata : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed vector table, corner sequences, and random
// traffic against a transaction-level reference model.
module tb_bus_arbiter;
  localparam int TO  = 8;
  localparam int MAXS = 4;

  logic        clock = 0, reset = 0;
  logic        f_req = 0, d_req = 0, d_write = 0, bus_ready = 0;
  logic [31:0] f_addr = 0, d_addr = 0, d_wdata = 0, bus_rdata = 0;
  logic [3:0]  d_wstrb = 0;
  logic        f_ack, f_err, d_ack, d_err, bus_valid, bus_write;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;

  int vectors = 0, miscompares = 0;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_err(f_err),
    .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_ack(d_ack), .d_err(d_err), .rdata(rdata),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic fr; logic [31:0] fa; logic dr; logic [31:0] da; logic dw;
    logic [31:0] dwd; logic [3:0] dws; logic rdy; logic [31:0] brd;
    logic ebv; logic [31:0] eaddr; logic ebw; logic [31:0] ewd; logic [3:0] ews;
    logic efa; logic eda; logic eerr; logic [31:0] erd;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  // Timeout run: load held with no ready; optionally ready arrives on the 8th grant cycle
  task automatic to_run(input bit rdy8, input string nm);
    int n = 0;
    bit got = 0;
    f_req = 0; d_req = 1; d_write = 0; d_addr = 32'h600; d_wdata = 0; d_wstrb = 0;
    bus_ready = 0; bus_rdata = 32'h55;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (bus_valid) n++;
      bus_ready = rdy8 && bus_valid && (n == TO);
      #1;
      if (d_ack) begin
        got = 1;
        chk({nm, " ack cycle"}, 64'(n), 64'(TO));
        chk({nm, " d_err"}, 64'(d_err), rdy8 ? 64'd0 : 64'd1);
        chk({nm, " rdata"}, 64'(rdata), rdy8 ? 64'h55 : 64'd0);
      end
      nxt();
    end
    chk({nm, " acked"}, 64'(got), 64'd1);
    d_req = 0; bus_ready = 0;
    #2 chk({nm, " bus_valid after"}, 64'(bus_valid), 64'd0);
    nxt();
  endtask

  initial begin
    vec_t tbl[8];
    int   grants[$];
    int   owner, dcnt, waited, rp;
    bit   fp, dp, done;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_ws;
    logic        e_w;

    tbl[0] = '{1, 32'h100, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 32'h100, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1, 32'h100, 0, 0, 0, 1, 0, 0, 32'hDEADBEEF};
    tbl[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{1, 32'h300, 1, 32'h200, 1, 32'h12345678, 4'hF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{1, 32'h300, 1, 32'h200, 1, 32'h12345678, 4'hF, 1, 0, 1, 32'h200, 1, 32'h12345678, 4'hF, 0, 1, 0, 0};
    tbl[5] = '{1, 32'h300, 0, 0, 0, 0, 0, 1, 0,            0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[6] = '{1, 32'h300, 0, 0, 0, 0, 0, 1, 32'hA5,       1, 32'h300, 0, 0, 0, 1, 0, 0, 32'hA5};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, 0, 0, 0, 0, 0};

    // Reset state
    #12;
    chk("reset bus_valid", 64'(bus_valid), 0);
    chk("reset f_ack", 64'(f_ack), 0);
    chk("reset d_ack", 64'(d_ack), 0);
    @(posedge clock); #1 reset = 1;

    // Directed table: single fetch, then contention
    foreach (tbl[i]) begin
      f_req = tbl[i].fr; f_addr = tbl[i].fa; d_req = tbl[i].dr; d_addr = tbl[i].da;
      d_write = tbl[i].dw; d_wdata = tbl[i].dwd; d_wstrb = tbl[i].dws;
      bus_ready = tbl[i].rdy; bus_rdata = tbl[i].brd;
      #2;
      chk($sformatf("tbl%0d bus_valid", i), 64'(bus_valid), 64'(tbl[i].ebv));
      chk($sformatf("tbl%0d bus_addr", i), 64'(bus_addr), 64'(tbl[i].eaddr));
      chk($sformatf("tbl%0d bus_write", i), 64'(bus_write), 64'(tbl[i].ebw));
      chk($sformatf("tbl%0d bus_wdata", i), 64'(bus_wdata), 64'(tbl[i].ewd));
      chk($sformatf("tbl%0d bus_wstrb", i), 64'(bus_wstrb), 64'(tbl[i].ews));
      chk($sformatf("tbl%0d f_ack", i), 64'(f_ack), 64'(tbl[i].efa));
      chk($sformatf("tbl%0d d_ack", i), 64'(d_ack), 64'(tbl[i].eda));
      if (tbl[i].efa) chk($sformatf("tbl%0d f_err", i), 64'(f_err), 64'(tbl[i].eerr));
      if (tbl[i].eda) chk($sformatf("tbl%0d d_err", i), 64'(d_err), 64'(tbl[i].eerr));
      if (tbl[i].efa || tbl[i].eda) chk($sformatf("tbl%0d rdata", i), 64'(rdata), 64'(tbl[i].erd));
      nxt();
    end

    // Starvation cap: both held, ready always -> D,D,D,D,F repeating
    f_req = 1; f_addr = 32'h400; d_req = 1; d_addr = 32'h500; d_write = 0;
    d_wdata = 0; d_wstrb = 0; bus_ready = 1; bus_rdata = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (f_ack && d_ack) chk("starve dual ack", 1, 0);
      if (f_ack) grants.push_back(1);
      if (d_ack) grants.push_back(2);
      nxt();
    end
    chk("starve grant count", 64'(grants.size()), 10);
    for (int k = 0; k < 10 && k < grants.size(); k++)
      chk($sformatf("starve grant%0d", k), 64'(grants[k]), (k % 5 == 4) ? 64'd1 : 64'd2);
    f_req = 0; d_req = 0; bus_ready = 0;
    nxt();

    to_run(0, "timeout");
    to_run(1, "ready at expiry");

    // Reset mid-transaction: bus_valid drops without a clock edge, no ack
    d_req = 1; d_write = 0; d_addr = 32'h680; bus_ready = 0;
    nxt(); nxt(); nxt();
    chk("midrst granted", 64'(bus_valid), 1);
    #1 reset = 0;
    #1 chk("midrst bus_valid", 64'(bus_valid), 0);
    chk("midrst d_ack", 64'(d_ack), 0);
    nxt();
    chk("midrst held d_ack", 64'(d_ack), 0);
    d_req = 0; f_req = 1; f_addr = 32'h700; reset = 1;
    #2 chk("post rst idle", 64'(bus_valid), 0);
    nxt();
    bus_ready = 1; bus_rdata = 32'h77;
    #1;
    chk("post rst F valid", 64'(bus_valid), 1);
    chk("post rst F addr", 64'(bus_addr), 32'h700);
    chk("post rst F ack", 64'(f_ack), 1);
    chk("post rst F rdata", 64'(rdata), 32'h77);
    nxt();
    f_req = 0; bus_ready = 0;

    // Random traffic vs transaction-level model
    reset = 0; nxt(); reset = 1;
    owner = 0; dcnt = 0; waited = 0; fp = 0; dp = 0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      if (!fp && $urandom % 3 == 0) begin fp = 1; f_addr = $urandom; end
      if (!dp && $urandom % 3 == 0) begin
        dp = 1; d_addr = $urandom; d_write = 1'($urandom); d_wdata = $urandom; d_wstrb = 4'($urandom);
      end
      f_req = fp; d_req = dp;
      rp = (cyc / 150) % 3;
      bus_ready = (rp == 0) ? 1'($urandom) : (rp == 1) ? 1'b1 : ($urandom % 16 == 0);
      bus_rdata = $urandom;
      #2;
      done   = (owner != 0) && (bus_ready || waited == TO - 1);
      e_addr = (owner == 1) ? f_addr : (owner == 2) ? d_addr : 32'h0;
      e_w    = (owner == 2) && d_write;
      e_wd   = (owner == 2) ? d_wdata : 32'h0;
      e_ws   = (owner == 2) ? d_wstrb : 4'h0;
      chk("rnd bus_valid", 64'(bus_valid), 64'(owner != 0));
      chk("rnd bus_addr", 64'(bus_addr), 64'(e_addr));
      chk("rnd bus_write", 64'(bus_write), 64'(e_w));
      chk("rnd bus_wdata", 64'(bus_wdata), 64'(e_wd));
      chk("rnd bus_wstrb", 64'(bus_wstrb), 64'(e_ws));
      chk("rnd f_ack", 64'(f_ack), 64'(done && owner == 1));
      chk("rnd d_ack", 64'(d_ack), 64'(done && owner == 2));
      if (done && owner == 1) chk("rnd f_err", 64'(f_err), 64'(!bus_ready));
      if (done && owner == 2) chk("rnd d_err", 64'(d_err), 64'(!bus_ready));
      if (done) chk("rnd rdata", 64'(rdata), bus_ready ? 64'(bus_rdata) : 64'd0);
      if (owner == 0) begin
        if (dp && (!fp || dcnt < MAXS)) begin
          owner = 2; waited = 0; dcnt = fp ? ((dcnt < 15) ? dcnt + 1 : 15) : 0;
        end else if (fp) begin
          owner = 1; waited = 0; dcnt = 0;
        end
      end else if (done) begin
        if (owner == 1) fp = 0; else dp = 0;
        owner = 0;
      end else begin
        waited++;
      end
      nxt();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
